// File: rtl/ctrl_link_pkg.sv
// Shared definitions for the 3-lane configuration load link: FSM encoding,
// default lane widths, the frame marker and the frame-length derivation.
package ctrl_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int VREF_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int CONV_W_DEF = 8;

  localparam logic MARKER_BIT = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Frame length: one marker bit plus the widest payload.
  function automatic int frame_len(input int vw, input int dw, input int cw);
    return 1 + max3(vw, dw, cw);
  endfunction

  function automatic int cnt_width(input int l, input int clr);
    int m;
    m = (l > clr) ? l : clr;
    return $clog2(m + 1);
  endfunction

  localparam int FRAME_L_DEF = frame_len(VREF_W_DEF, DATA_W_DEF, CONV_W_DEF);

endpackage

// File: rtl/ctrl_frame_tx_if.sv
// Host-side load request and serial link signals of the frame transmitter.
// master = host/test controller, slave = ctrl_frame_tx.
interface ctrl_frame_tx_if
  import ctrl_link_pkg::*;
#(
  parameter int VREF_W = VREF_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CONV_W = CONV_W_DEF
) ();

  logic              load;
  logic [VREF_W-1:0] vref_in;
  logic [DATA_W-1:0] data_in;
  logic [CONV_W-1:0] conv_in;
  logic              ready;
  logic              done;
  logic              rx_clr_n;
  logic              sd_vref;
  logic              sd_data;
  logic              sd_conv;

  modport master (
    output load, vref_in, data_in, conv_in,
    input  ready, done, rx_clr_n, sd_vref, sd_data, sd_conv
  );

  modport slave (
    input  load, vref_in, data_in, conv_in,
    output ready, done, rx_clr_n, sd_vref, sd_data, sd_conv
  );

endinterface

// File: rtl/frame_lane_ser.sv
// One serial lane: registers the frame bit for the index it will be showing
// next cycle (marker, then payload LSB-first, then zero padding).
module frame_lane_ser
  import ctrl_link_pkg::*;
#(
  parameter int W     = 8,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [W-1:0]     i_payload,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_sd
);

  logic w_bit;
  logic r_sd_p1;

  // Compare-based select so the index can never address past the payload MSB.
  always_comb begin
    w_bit = 1'b0;
    if (i_idx == '0) begin
      w_bit = MARKER_BIT;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (i_idx == IDX_W'(i + 1)) begin
          w_bit = i_payload[i];
        end
      end
    end
  end

  // ---- stage p1: registered lane output ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sd_p1 <= 1'b0;
    end else begin
      r_sd_p1 <= i_en & w_bit;
    end
  end

  assign o_sd = r_sd_p1;

endmodule

// File: rtl/ctrl_frame_tx.sv
// Three-lane marker-framed serial transmitter: on load it pulses the loader
// clear for CLR_CYCLES cycles, then shifts all three frames out in parallel.
module ctrl_frame_tx
  import ctrl_link_pkg::*;
#(
  parameter int VREF_W     = VREF_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CONV_W     = CONV_W_DEF,
  parameter int CLR_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  ctrl_frame_tx_if.slave bus
);

  localparam int L     = frame_len(VREF_W, DATA_W, CONV_W);
  localparam int CNT_W = cnt_width(L, CLR_CYCLES);

  generate
    if (CLR_CYCLES < 1 || CLR_CYCLES > 15) begin : g_bad_clr
      $error("ctrl_frame_tx: CLR_CYCLES must be in 1..15");
    end
  endgenerate

  state_t            r_state;
  state_t            w_state_nx;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic [VREF_W-1:0] r_vref;
  logic [DATA_W-1:0] r_data;
  logic [CONV_W-1:0] r_conv;
  logic              w_accept;
  logic              w_lane_en;

  assign w_accept = (r_state == ST_IDLE) && bus.load;

  // ---- stage p0: state, counter and payload capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_vref  <= '0;
      r_data  <= '0;
      r_conv  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_accept) begin
        r_vref <= bus.vref_in;
        r_data <= bus.data_in;
        r_conv <= bus.conv_in;
      end
    end
  end

  // w_cnt_nx doubles as the lane bit index: lanes register the bit for the
  // index the FSM is about to enter, so bit k is visible for all of cycle k.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_lane_en  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.load) begin
          w_state_nx = ST_CLR;
          w_cnt_nx   = '0;
        end
      end
      ST_CLR: begin
        if (r_cnt == CNT_W'(CLR_CYCLES - 1)) begin
          w_state_nx = ST_SHIFT;
          w_cnt_nx   = '0;
          w_lane_en  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (r_cnt == CNT_W'(L - 1)) begin
          w_state_nx = ST_DONE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx  = r_cnt + CNT_W'(1);
          w_lane_en = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  assign bus.ready    = (r_state == ST_IDLE);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.rx_clr_n = (r_state != ST_CLR);

  // ---- stage p1: serial lanes ----
  frame_lane_ser #(.W(VREF_W), .IDX_W(CNT_W)) u_lane_vref (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_lane_en),
    .i_payload (r_vref),
    .i_idx     (w_cnt_nx),
    .o_sd      (bus.sd_vref)
  );

  frame_lane_ser #(.W(DATA_W), .IDX_W(CNT_W)) u_lane_data (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_lane_en),
    .i_payload (r_data),
    .i_idx     (w_cnt_nx),
    .o_sd      (bus.sd_data)
  );

  frame_lane_ser #(.W(CONV_W), .IDX_W(CNT_W)) u_lane_conv (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_lane_en),
    .i_payload (r_conv),
    .i_idx     (w_cnt_nx),
    .o_sd      (bus.sd_conv)
  );

  a_done_not_ready : assert property (@(posedge clk) disable iff (rst)
    bus.done |-> !bus.ready);
  a_clr_quiet_lanes : assert property (@(posedge clk) disable iff (rst)
    !bus.rx_clr_n |-> !(bus.sd_vref | bus.sd_data | bus.sd_conv));

endmodule

// File: tb/tb_ctrl_frame_tx.sv
// Scoreboard bench for ctrl_frame_tx: stimulus queues hand-computed frames,
// a monitor deserialises the lanes, runs loopback loaders and checks on done.
module tb_ctrl_frame_tx;

  localparam int VW  = 4;
  localparam int DW  = 8;
  localparam int CW  = 8;
  localparam int LAT = 12;

  typedef struct {
    logic [VW-1:0] v;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic [8:0]    vs;
    logic [8:0]    ds;
    logic [8:0]    cs;
    int            lc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_pass;
  int   n_done;
  exp_t exp_q[$];

  ctrl_frame_tx_if #(.VREF_W(VW), .DATA_W(DW), .CONV_W(CW)) bus ();

  ctrl_frame_tx #(.VREF_W(VW), .DATA_W(DW), .CONV_W(CW), .CLR_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end else begin
      n_pass++;
    end
  endtask

  // Loopback marker-framed loaders, cleared by rx_clr_n, frozen once the
  // marker reaches the stop position.
  logic [VW:0] ld_v;
  logic [DW:0] ld_d;
  logic [CW:0] ld_c;
  always @(posedge clk) begin
    if (!bus.rx_clr_n) begin
      ld_v <= '0;
      ld_d <= '0;
      ld_c <= '0;
    end else begin
      if (ld_v[0] == 1'b0) ld_v <= {bus.sd_vref, ld_v[VW:1]};
      if (ld_d[0] == 1'b0) ld_d <= {bus.sd_data, ld_d[DW:1]};
      if (ld_c[0] == 1'b0) ld_c <= {bus.sd_conv, ld_c[CW:1]};
    end
  end

  // Monitor
  int         clr_cnt;
  int         bidx;
  bit         armed;
  logic [8:0] cap_v, cap_d, cap_c;
  initial begin
    clr_cnt = 0; bidx = 0; armed = 0; n_done = 0;
    cap_v = '0; cap_d = '0; cap_c = '0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      clr_cnt = 0; bidx = 0; armed = 0;
    end else begin
      if (!bus.rx_clr_n) begin
        clr_cnt++;
        armed = 1; bidx = 0;
        cap_v = '0; cap_d = '0; cap_c = '0;
      end else if (armed && bidx < 9) begin
        cap_v[bidx] = bus.sd_vref;
        cap_d[bidx] = bus.sd_data;
        cap_c[bidx] = bus.sd_conv;
        bidx++;
      end
      if (bus.done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("stream_vref", 32'(cap_v), 32'(e.vs));
          chk("stream_data", 32'(cap_d), 32'(e.ds));
          chk("stream_conv", 32'(cap_c), 32'(e.cs));
          chk("clr_cycles", 32'(clr_cnt), 32'd2);
          chk("done_latency", 32'(cyc - e.lc), 32'(LAT));
          chk("ready_in_done", 32'(bus.ready), 32'd0);
          chk("loop_vref", 32'(ld_v), 32'({e.v, 1'b1}));
          chk("loop_data", 32'(ld_d), 32'({e.d, 1'b1}));
          chk("loop_conv", 32'(ld_c), 32'({e.c, 1'b1}));
        end
        armed = 0; clr_cnt = 0;
      end
    end
  end

  task automatic check_idle(input string nm);
    chk({nm, "_ready"}, 32'(bus.ready), 32'd1);
    chk({nm, "_done"}, 32'(bus.done), 32'd0);
    chk({nm, "_clr_n"}, 32'(bus.rx_clr_n), 32'd1);
    chk({nm, "_lanes"}, 32'({bus.sd_vref, bus.sd_data, bus.sd_conv}), 32'd0);
  endtask

  // Called just after a rising edge; presents load for one cycle.
  task automatic do_load(input logic [VW-1:0] v, input logic [DW-1:0] d,
                         input logic [CW-1:0] c, input logic [8:0] vs,
                         input logic [8:0] ds, input logic [8:0] cs,
                         input bit expect_accept);
    exp_t e;
    bus.vref_in = v;
    bus.data_in = d;
    bus.conv_in = c;
    bus.load    = 1'b1;
    if (expect_accept) begin
      e.v = v; e.d = d; e.c = c; e.vs = vs; e.ds = ds; e.cs = cs; e.lc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk) #1;
    bus.load = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b0;
    bus.load = 1'b0; bus.vref_in = '0; bus.data_in = '0; bus.conv_in = '0;

    // Reset asserted mid-cycle takes effect immediately
    #7 rst = 1'b1;
    #1 check_idle("rst_now");
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("idle_hold");

    // Basic frame with an ignored load (and payload change) at cycle 5
    @(posedge clk) #1;
    do_load(4'hA, 8'h3C, 8'h81, 9'h015, 9'h079, 9'h103, 1'b1);
    repeat (4) @(posedge clk) #1;
    do_load(4'hF, 8'hFF, 8'hFF, 9'h0, 9'h0, 9'h0, 1'b0);
    wait_done();
    @(negedge clk);
    check_idle("after_frame1");

    // Reset during SHIFT index 4 (cycle 7 after the load)
    @(posedge clk) #1;
    do_load(4'h6, 8'h99, 8'h42, 9'h0, 9'h0, 9'h0, 1'b0);
    repeat (6) @(posedge clk) #1;
    #2 chk("idx4_data", 32'(bus.sd_data), 32'd1);
    rst = 1'b1;
    #1 check_idle("rst_mid");
    @(negedge clk);
    @(negedge clk) rst = 1'b0;

    // Reload after reset, then back-to-back on the first ready cycle
    @(posedge clk) #1;
    do_load(4'h3, 8'h55, 8'h00, 9'h007, 9'h0AB, 9'h001, 1'b1);
    wait_done();
    @(posedge clk) #1;
    chk("b2b_ready", 32'(bus.ready), 32'd1);
    do_load(4'h5, 8'hC3, 8'h7E, 9'h00B, 9'h187, 9'h0FD, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);

    chk("done_count", 32'(n_done), 32'd3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ctrl_frame_tx.md
Name: ctrl_frame_tx

Overview:
- Serial transmitter for the 3-lane configuration load link: vref, data and conver words.
- Sits on the host/test side. Each lane drives one serial input of the marker-framed shift-register loader.
- On each load it first pulses the loader's active-low clear, then sends all three frames in parallel, one bit per clock.
- Frame format per lane: a single '1' marker bit, then the payload LSB-first. After the last payload bit the lane drives 0.

Parameters:
- VREF_W, 4, vref payload width in bits
- DATA_W, 8, data payload width in bits
- CONV_W, 8, conver payload width in bits
- CLR_CYCLES, 2, number of cycles rx_clr_n is held low before the frames start (legal range 1..15)

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- load  in  1  one-cycle request; captures vref_in, data_in and conv_in when ready=1
- vref_in  in  VREF_W  vref payload
- data_in  in  DATA_W  data payload
- conv_in  in  CONV_W  conver payload
- ready  out  1  high in IDLE; the block accepts load only while ready=1
- done  out  1  one-cycle pulse after the last bit of the longest frame
- rx_clr_n  out  1  active-low clear to the loader
- sd_vref  out  1  serial vref lane
- sd_data  out  1  serial data lane
- sd_conv  out  1  serial conver lane

Behaviour:
- Reset (asynchronous assert, takes effect immediately):
  - state=IDLE, ready=1, done=0, rx_clr_n=1
  - sd_vref, sd_data, sd_conv = 0
  - payload registers and counter cleared
- FSM states: IDLE -> CLR -> SHIFT -> DONE -> IDLE.
- IDLE:
  - Lanes drive 0, rx_clr_n=1.
  - load=1 at an edge registers all three payloads; next state is CLR.
  - A load seen when ready=0 is ignored. There is no queueing and no error flag.
- CLR:
  - rx_clr_n=0 for exactly CLR_CYCLES cycles; lanes stay 0.
  - The counter runs 0..CLR_CYCLES-1, then the FSM moves to SHIFT with the bit index cleared to 0.
- SHIFT:
  - The bit index k runs 0..L-1, where L = 1 + max(VREF_W, DATA_W, CONV_W). L is a derived localparam (9 at the defaults).
  - Lane output at index k, for a lane of width W:
    - k=0: 1 (marker)
    - 1<=k<=W: payload[k-1]
    - k>W: 0
  - The lanes are independent; a shorter lane idles at 0 while the longer lanes finish.
  - Lane outputs are registered. The value for index k is visible for the whole cycle k.
  - rx_clr_n=1 throughout SHIFT.
- DONE:
  - One cycle with done=1, lanes at 0, ready=0.
  - Next state is IDLE, with ready=1 on the following cycle.
- Latency:
  - Load edge at cycle 0; rx_clr_n is low during cycles 1..CLR_CYCLES.
  - Marker bits appear at cycle CLR_CYCLES+1.
  - done is high at cycle CLR_CYCLES+L+1.
  - At the defaults the total is 12 cycles from load to done.
- ready is low from the cycle after an accepted load until DONE has finished.
- Payload inputs are sampled only at the accepting edge. Later changes on vref_in, data_in or conv_in have no effect on the frame in flight.
- Reset mid-frame:
  - All outputs return to their reset values immediately.
  - A partial frame may be left in the loader. This is acceptable because every new load starts with CLR.
- Counter width is $clog2(max(L, CLR_CYCLES)+1). Indexing must never read past a payload's MSB.

Decomposition:
- Shared package ctrl_link_pkg holds:
  - FSM state enum
  - VREF_W, DATA_W and CONV_W defaults
  - MARKER_BIT = 1'b1
  - the L derivation
- One natural sub-module, frame_lane_ser, instantiated three times:
  - Inputs: payload (width W) and bit index.
  - Output: registered serial bit following the marker/LSB-first/zero-pad rule.

Test Plan:
- Reset then idle: assert rst mid-cycle -> all lanes 0, rx_clr_n=1, ready=1, done=0 immediately and held while idle.
- Basic frame: load with vref_in=4'hA, data_in=8'h3C, conv_in=8'h81 ->
  - rx_clr_n low for cycles 1-2
  - sd_vref = 1,0,1,0,1,0,0,0,0
  - sd_data = 1,0,0,1,1,1,1,0,0
  - sd_conv = 1,1,0,0,0,0,0,0,1
  - done at cycle 12
- Loopback: connect to three marker-framed loaders (loader reset = rx_clr_n) -> after done the loaders hold vref=A, data=3C, conver=81, with their stop bits set and shifting frozen.
- Load while busy: second load with data_in=8'hFF at cycle 5 -> ignored; frame still carries 3C and exactly one done pulse occurs.
- Reset mid-operation: assert rst at the SHIFT index 4 cycle -> outputs return to reset values at once. A new load of 8'h55 then clears and reloads, and the loopback data reads 55.
- Back-to-back: issue load on the first cycle ready=1 after done -> the new CLR starts with no gap, and the second frame's values are correct.
